// File: rtl/msrv32_dmem_ahb_responder_if.sv
// Bus bundle between the core's data port (master) and the data-memory responder (slave).
// Address-phase fields, write data and the ready/response/read-data return path.
interface msrv32_dmem_ahb_responder_if;
    logic [31:0] d_addr_in;
    logic [1:0]  htrans_in;
    logic        wr_req_in;
    logic [3:0]  wr_mask_in;
    logic [31:0] data_in;
    logic [31:0] rd_data_out;
    logic        ahb_ready_out;
    logic        hresp_out;

    modport master (
        output d_addr_in,
        output htrans_in,
        output wr_req_in,
        output wr_mask_in,
        output data_in,
        input  rd_data_out,
        input  ahb_ready_out,
        input  hresp_out
    );

    modport slave (
        input  d_addr_in,
        input  htrans_in,
        input  wr_req_in,
        input  wr_mask_in,
        input  data_in,
        output rd_data_out,
        output ahb_ready_out,
        output hresp_out
    );
endinterface

// File: rtl/msrv32_dmem_ahb_responder.sv
// AHB-lite style data-memory slave: byte-masked word writes, registered reads,
// programmable wait states and a two-cycle error response for out-of-range words.
module msrv32_dmem_ahb_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                         ms_riscv32_mp_clk_in,
    input  logic                         ms_riscv32_mp_rst_in,
    msrv32_dmem_ahb_responder_if.slave   bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    waitCnt_q, waitCnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_q, wr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   rdData_q, rdData_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          ready;
    logic          hresp;
    logic          accept;
    logic          inRange;
    logic [AW-1:0] reqIdx;
    logic          commit;
    logic          loadRd;
    logic [31:0]   rdWord;
    logic          unusedAddrBits;

    assign unusedAddrBits = ^bus.d_addr_in[1:0];
    assign reqIdx  = bus.d_addr_in[AW+1:2];
    assign inRange = {2'b00, bus.d_addr_in[31:2]} < DEPTH_LIMIT;

    // Next-state, handshake outputs and read-data selection. A read entering DONE in
    // the same edge that a write to the same word commits takes the merged write data.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        mask_d    = mask_q;
        ready     = 1'b1;
        hresp     = 1'b0;
        commit    = 1'b0;
        loadRd    = 1'b0;
        rdWord    = '0;
        rdData_d  = rdData_q;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_WAIT: begin
                ready = 1'b0;
            end
            S_DONE: begin
                ready  = 1'b1;
                commit = wr_q;
            end
            S_ERR1: begin
                ready = 1'b0;
                hresp = 1'b1;
            end
            S_ERR2: begin
                ready = 1'b1;
                hresp = 1'b1;
            end
            default: begin
                ready = 1'b1;
            end
        endcase

        accept = bus.htrans_in[1] & ready;

        case (state_q)
            S_WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            idx_d  = reqIdx;
            wr_d   = bus.wr_req_in;
            mask_d = bus.wr_mask_in;
            if (!inRange) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d   = S_WAIT;
                waitCnt_d = WAIT_INIT;
            end else begin
                state_d = S_DONE;
            end
        end

        loadRd = (state_d == S_DONE) && !wr_d;
        if (loadRd) begin
            rdWord = mem[idx_d];
            if (commit && (idx_q == idx_d)) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask_q[b]) begin
                        rdWord[8*b +: 8] = bus.data_in[8*b +: 8];
                    end
                end
            end
            rdData_d = rdWord;
        end
    end

    // Control and read-data registers; memory contents are deliberately not reset.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q   <= S_IDLE;
            waitCnt_q <= 4'd0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            mask_q    <= 4'd0;
            rdData_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            mask_q    <= mask_d;
            rdData_q  <= rdData_d;
        end
    end

    // Byte-lane write at the closing edge of a write data phase; reset aborts it.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.data_in[8*b +: 8];
                end
            end
        end
    end

    assign bus.ahb_ready_out = ready;
    assign bus.hresp_out     = hresp;
    assign bus.rd_data_out   = rdData_q;

endmodule
